// File: rtl/data_mem_port_pkg.sv
// Shared types for the CPU memory-access stage and its data-memory responder.
package data_mem_port_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [1:0] {
    MA_X     = 2'b00,
    MA_LOAD  = 2'b01,
    MA_STORE = 2'b10
  } ma_mode_t;

  typedef enum logic [2:0] {
    MA_B  = 3'b000,
    MA_H  = 3'b001,
    MA_W  = 3'b010,
    MA_BU = 3'b100,
    MA_HU = 3'b101
  } ma_size_t;

  localparam word_t MEM_RSP_NULL = 32'h0;

endpackage

// File: rtl/data_mem_port_if.sv
// Request/response channel plus word-wide BRAM port of the data-memory responder.
interface data_mem_port_if #(
  parameter int MEM_BYTES = 4096,
  parameter int MEM_AW    = $clog2(MEM_BYTES) - 2
);
  import data_mem_port_pkg::*;

  // Both channels: a beat transfers on a rising clock edge where valid && ready;
  // the sender holds its payload stable while valid is high and ready is low.
  logic              req_valid_i;
  logic              req_ready_o;
  ma_mode_t          req_mode_i;
  ma_size_t          req_size_i;
  word_t             req_addr_i;
  word_t             req_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  word_t             rsp_data_o;
  logic              rsp_fault_o;
  logic [MEM_AW-1:0] mem_addr_o;
  byte_en_t          mem_we_o;
  word_t             mem_wdata_o;
  word_t             mem_rdata_i;

  modport slave (
    input  req_valid_i, req_mode_i, req_size_i, req_addr_i, req_data_i,
    input  rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_fault_o,
    output mem_addr_o, mem_we_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_mode_i, req_size_i, req_addr_i, req_data_i,
    output rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_fault_o,
    input  mem_addr_o, mem_we_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half lane out of a BRAM word and sign/zero-extends it.
module mem_load_align
  import data_mem_port_pkg::*;
(
  input  word_t       rdata,
  input  ma_size_t    size,
  input  logic [1:0]  off,
  output word_t       data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    data   = MEM_RSP_NULL;
    case (size)
      MA_B:    data = {{24{lane_b[7]}}, lane_b};
      MA_BU:   data = {24'h0, lane_b};
      MA_H:    data = {{16{lane_h[15]}}, lane_h};
      MA_HU:   data = {16'h0, lane_h};
      MA_W:    data = rdata;
      default: data = MEM_RSP_NULL;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// Memory-side responder: checks load/store requests, drives a synchronous BRAM
// and returns extended load data or a store completion over a response channel.
module data_mem_port
  import data_mem_port_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  data_mem_port_if.slave  bus,
  output logic [1:0]      dbg_state_o
);

  localparam int MEM_AW = $clog2(MEM_BYTES) - 2;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  word_t             rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;
  ma_size_t          ld_size_q;
  logic [1:0]        ld_off_q;
  logic [MEM_AW-1:0] mem_addr_q;
  word_t             ld_data;
  logic              accept, is_mem, misalign, fault;
  byte_en_t          we_lane;
  word_t             wdata_lane;

  // Ready is a function of state and the response sink only, never of req_valid_i.
  assign bus.req_ready_o = reset_n_i &&
                           ((state_q == IDLE) || (state_q == RESP && bus.rsp_ready_i));
  assign accept = bus.req_valid_i && bus.req_ready_o;
  assign is_mem = (bus.req_mode_i == MA_LOAD) || (bus.req_mode_i == MA_STORE);

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size_i)
      MA_B, MA_BU: misalign = 1'b0;
      MA_H, MA_HU: misalign = bus.req_addr_i[0];
      MA_W:        misalign = |bus.req_addr_i[1:0];
      default:     misalign = 1'b1;
    endcase
    fault = is_mem && (misalign || (bus.req_addr_i >= 32'(MEM_BYTES)));
  end

  always_comb begin
    we_lane    = 4'b1111;
    wdata_lane = bus.req_data_i;
    case (bus.req_size_i[1:0])
      2'b00: begin
        we_lane    = 4'b0001 << bus.req_addr_i[1:0];
        wdata_lane = {4{bus.req_data_i[7:0]}};
      end
      2'b01: begin
        we_lane    = 4'b0011 << bus.req_addr_i[1:0];
        wdata_lane = {2{bus.req_data_i[15:0]}};
      end
      default: begin
        we_lane    = 4'b1111;
        wdata_lane = bus.req_data_i;
      end
    endcase
  end

  assign bus.mem_we_o    = (accept && bus.req_mode_i == MA_STORE && !fault) ? we_lane : '0;
  assign bus.mem_wdata_o = wdata_lane;
  assign bus.mem_addr_o  = accept ? bus.req_addr_i[MEM_AW+1:2] : mem_addr_q;

  mem_load_align u_align (
    .rdata (bus.mem_rdata_i),
    .size  (ld_size_q),
    .off   (ld_off_q),
    .data  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      LOAD_WAIT: begin
        state_d     = RESP;
        rsp_data_d  = ld_data;
        rsp_fault_d = 1'b0;
      end
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = state_q;
    endcase
    // An accept in RESP retires the old response and starts the new one.
    if (accept) begin
      rsp_data_d  = MEM_RSP_NULL;
      rsp_fault_d = fault;
      state_d     = (bus.req_mode_i == MA_LOAD && !fault) ? LOAD_WAIT : RESP;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      rsp_data_q  <= MEM_RSP_NULL;
      rsp_fault_q <= 1'b0;
      ld_size_q   <= MA_B;
      ld_off_q    <= 2'b00;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      if (accept) begin
        ld_size_q  <= bus.req_size_i;
        ld_off_q   <= bus.req_addr_i[1:0];
        mem_addr_q <= bus.req_addr_i[MEM_AW+1:2];
      end
    end
  end

  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_fault_o = rsp_fault_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: BRAM model, byte-level reference memory, directed and random traffic.
module tb_data_mem_port;
  import data_mem_port_pkg::*;

  localparam int MEM_BYTES = 4096;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n_i = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  data_mem_port_if #(.MEM_BYTES(MEM_BYTES)) bus ();

  data_mem_port #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Synchronous BRAM: read data one cycle after address, byte-enabled writes.
  logic [31:0] bram [MEM_BYTES/4] = '{default: '0};
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (bus.mem_we_o[k]) bram[bus.mem_addr_o][8*k +: 8] <= bus.mem_wdata_o[8*k +: 8];
    bus.mem_rdata_i <= bram[bus.mem_addr_o];
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [MEM_BYTES] = '{default: '0};
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_fault(input logic [1:0] mode, input logic [2:0] size,
                                   input logic [31:0] addr);
    if (mode != 2'd1 && mode != 2'd2) return 1'b0;
    if (addr >= MEM_BYTES) return 1'b1;
    if (size == 3'd3 || size == 3'd6 || size == 3'd7) return 1'b1;
    if (size[1:0] == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size[1:0] == 2'd2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] size, input logic [31:0] addr);
    int          n;
    logic [31:0] v;
    n = 1 << size[1:0];
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
    if (!size[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic [1:0] mode, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] data, input int stall);
    bit          f;
    bit          is_st, is_ld;
    logic [31:0] ed, ew;
    logic [3:0]  ewe;
    int          n, lat, t, elat;
    f     = exp_fault(mode, size, addr);
    is_st = !f && mode == 2'd2;
    is_ld = !f && mode == 2'd1;
    ed    = is_ld ? exp_load(size, addr) : 32'h0;
    elat  = is_ld ? 2 : 1;
    n     = 1 << size[1:0];
    ewe   = 4'h0;
    ew    = 32'h0;
    if (is_st)
      for (int k = 0; k < 4; k++) begin
        if (k >= int'(addr[1:0]) && k < int'(addr[1:0]) + n) ewe[k] = 1'b1;
        ew[8*k +: 8] = 8'(data >> (8 * (k % n)));
      end

    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = ma_mode_t'(mode);
    bus.req_size_i  = ma_size_t'(size);
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    bus.rsp_ready_i = 1'b1;
    #1;
    check_eq("req_ready", 32'(bus.req_ready_o), 32'd1);
    t = 0;
    while (!bus.req_ready_o && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (!bus.req_ready_o) begin
      check_eq("req_ready_timeout", 32'd0, 32'd1);
      bus.req_valid_i = 1'b0;
      return;
    end
    check_eq("mem_we", 32'(bus.mem_we_o), 32'(ewe));
    if (is_st) check_eq("mem_wdata", bus.mem_wdata_o, ew);
    if (is_st || is_ld) check_eq("mem_addr", 32'(bus.mem_addr_o), 32'(addr[11:2]));
    if (is_st) for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(data >> (8 * i));

    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = (stall == 0);
    @(negedge clk);
    lat = 1;
    while (!bus.rsp_valid_o && lat < 8) begin
      check_eq("we_wait", 32'(bus.mem_we_o), 32'd0);
      @(negedge clk);
      lat++;
    end
    check_eq("rsp_latency", 32'(lat), 32'(elat));
    check_eq("rsp_data", bus.rsp_data_o, ed);
    check_eq("rsp_fault", 32'(bus.rsp_fault_o), 32'(f));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
      check_eq("stall_data", bus.rsp_data_o, ed);
      check_eq("stall_ready", 32'(bus.req_ready_o), 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_mode_i  = MA_X;
    bus.req_size_i  = MA_B;
    bus.req_addr_i  = 32'h0;
    bus.req_data_i  = 32'h0;
    bus.rsp_ready_i = 1'b1;
    #3;
    check_eq("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data_o, 32'h0);
    check_eq("rst_rsp_fault", 32'(bus.rsp_fault_o), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(bus.req_ready_o), 32'd1);

    // Directed: word store then signed byte load, byte store and unsigned reads.
    do_req(2'd2, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    do_req(2'd1, 3'd0, 32'h13, 32'h0, 0);
    do_req(2'd2, 3'd0, 32'h21, 32'h0000007F, 0);
    do_req(2'd1, 3'd4, 32'h21, 32'h0, 0);
    do_req(2'd1, 3'd5, 32'h20, 32'h0, 0);
    // Misaligned, out-of-range, undefined size and MA_X cases.
    do_req(2'd1, 3'd1, 32'h3, 32'h0, 0);
    do_req(2'd2, 3'd2, 32'h6, 32'h12345678, 0);
    do_req(2'd1, 3'd2, 32'h4, 32'h0, 0);
    do_req(2'd1, 3'd2, 32'h1000, 32'h0, 0);
    do_req(2'd2, 3'd3, 32'h8, 32'hFFFFFFFF, 0);
    do_req(2'd0, 3'd7, 32'hFFFFFFFF, 32'hA5A5A5A5, 0);
    do_req(2'd1, 3'd2, 32'h8, 32'h0, 0);
    // Back-pressure, then retire and accept in the same cycle.
    do_req(2'd1, 3'd2, 32'h10, 32'h0, 5);
    do_req(2'd2, 3'd2, 32'h24, 32'h0BADF00D, 0);
    do_req(2'd1, 3'd1, 32'h26, 32'h0, 0);

    // Reset while a load waits on the BRAM.
    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = MA_LOAD;
    bus.req_size_i  = MA_W;
    bus.req_addr_i  = 32'h10;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check_eq("midrst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check_eq("midrst_mem_we", 32'(bus.mem_we_o), 32'd0);
    check_eq("midrst_req_ready", 32'(bus.req_ready_o), 32'd0);
    check_eq("midrst_rsp_data", bus.rsp_data_o, 32'h0);
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("no_stale_rsp", 32'(bus.rsp_valid_o), 32'd0);
    end
    do_req(2'd1, 3'd4, 32'h12, 32'h0, 0);

    // Random traffic against the byte-level model.
    for (int it = 0; it < 300; it++) begin
      logic [1:0]  mode;
      logic [2:0]  size;
      logic [31:0] addr;
      int          r, stall;
      mode = 2'($urandom_range(0, 2));
      size = 3'($urandom_range(0, 7));
      r    = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'(MEM_BYTES - $urandom_range(0, 8));
      else begin
        addr = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
      end
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_req(mode, size, addr, $urandom, stall);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Memory-side responder for the CPU memory-access stage. It accepts load/store requests carrying ma_mode_t, ma_size_t, a byte address and store data, and drives a synchronous word-wide BRAM with byte write enables.
- It returns sign- or zero-extended load data, or a completion for stores, over a valid/ready response channel.
- It flags misaligned and out-of-range accesses as faults, without touching memory.

Parameters:
- MEM_BYTES, 4096, memory size in bytes; must be a power of two and at least 4.
- MEM_AW, $clog2(MEM_BYTES)-2, word-address width driven to the BRAM.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_mode_i  in  2  ma_mode_t (MA_X / MA_LOAD / MA_STORE)
- req_size_i  in  3  ma_size_t
- req_addr_i  in  32  byte address (word_t)
- req_data_i  in  32  store data, right-justified
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_data_o  out  32  extended load data; 0 for store, MA_X and fault
- rsp_fault_o  out  1  misaligned or out-of-range access
- mem_addr_o  out  MEM_AW  BRAM word address = req_addr_i[MEM_AW+1:2]
- mem_we_o  out  4  BRAM byte write enables
- mem_wdata_o  out  32  BRAM write data, lane-shifted
- mem_rdata_i  in  32  BRAM read data, valid one cycle after address

Behaviour:
- States: IDLE, LOAD_WAIT, RESP. Reset (async, reset_n_i=0) forces IDLE and clears the captured response to 0/0, regardless of in-flight operation.
- Reset values: req_ready_o=0 while reset is asserted, 1 after release; rsp_valid_o=0, rsp_data_o=0, rsp_fault_o=0, mem_we_o=0.
- req_ready_o = (state==IDLE) || (state==RESP && rsp_ready_i). A new request may be accepted in the same cycle the old response retires.
- Fault check on accept:
  - H/HU with addr[0]!=0 faults.
  - W with addr[1:0]!=0 faults.
  - Any req_addr_i >= MEM_BYTES faults, for MA_LOAD or MA_STORE.
  - B/BU never misalign.
  - Undefined size codes (3'b011, 3'b11x) fault.
- Faulting request: mem_we_o=0, go RESP with fault=1, data=0.
- MA_X request: no memory access, go RESP with fault=0, data=0. Size and address are ignored.
- Store accept (combinational in the accept cycle):
  - mem_addr_o is driven.
  - mem_we_o: B=4'b0001<<addr[1:0]; H=4'b0011<<addr[1:0]; W=4'b1111.
  - mem_wdata_o: byte replicated ×4; half replicated ×2; word as-is.
  - Next state RESP, data=0, fault=0. Store latency to response: 1 cycle.
- Load accept: mem_addr_o is driven and mem_we_o=0. Register size and addr[1:0]; go LOAD_WAIT.
- LOAD_WAIT:
  - Capture mem_rdata_i and select the byte/half lane by the registered addr[1:0].
  - Sign-extend for B/H; zero-extend for BU/HU; W passes through.
  - Go RESP. Load latency accept→rsp_valid_o: 2 cycles.
- RESP: rsp_valid_o=1; data and fault are held stable until rsp_ready_i. Then go IDLE, or go to the next request's path if one is accepted in that cycle.
- mem_we_o is non-zero only in an accept cycle of a legal store; it is never non-zero in LOAD_WAIT or RESP unless a store is accepted there.
- mem_addr_o outside accept cycles: don't-care but stable (holds the last value).
- req_ready_o never depends combinationally on req_valid_i.
- Throughput: one store per cycle under continuous rsp_ready_i; one load per 2 cycles.

Decomposition:
- common package additions: typedef logic [3:0] byte_en_t; localparam word_t MEM_RSP_NULL = 32'h0. The state enum stays local to the module.
- One combinational sub-module, mem_load_align (inputs: rdata, ma_size_t, addr[1:0]; output: word_t), holds the lane select and extension, so it is unit-testable in isolation.

Test Plan:
- Store W 0xDEADBEEF @0x10, then LB @0x13 → mem_we_o=4'b1111 in the accept cycle; load response 0xFFFFFFDE 2 cycles after accept, fault=0.
- SB 0x7F @0x21, then LBU @0x21 and LHU @0x20 → mem_we_o=4'b0010, mem_wdata_o=0x7F7F7F7F; responses 0x0000007F and 0x00007F00 (other bytes pre-zeroed).
- LH @0x3 and SW @0x6 → rsp_fault_o=1, rsp_data_o=0, mem_we_o stays 0, memory unchanged on readback.
- LW @MEM_BYTES (0x1000) → fault=1; MA_X @0xFFFFFFFF → fault=0, data=0, 1-cycle response.
- Hold rsp_ready_i=0 for 5 cycles after an LW → rsp_valid_o and data held, req_ready_o=0. Release → retire plus accept a new SW in the same cycle.
- Assert reset_n_i=0 in LOAD_WAIT → immediately rsp_valid_o=0, mem_we_o=0. After release, the first response corresponds to a new request only.
